// File: rtl/memory_receive_pkg.sv
// memory_receive_pkg
//   Encodings and helpers shared between the memory issue and receive stages.
//   - size_e : access size carried with every load (byte / half / word)
//   - log2   : ceiling log2, used to size offset fields and queue pointers
package memory_receive_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Ceiling log2; log2(1) == 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/memory_receive_load_formatter.sv
// memory_receive_load_formatter
//   Combinational load-data alignment: shift the returned word down to the
//   addressed byte, select byte/half/word and sign- or zero-extend it.
//   Ports:
//     data        in  returned aligned memory word
//     offset      in  byte offset of the load within the word
//     log2_bytes  in  access size (size_e encoding)
//     is_unsigned in  1 = zero-extend, 0 = sign-extend
//     result      out formatted, extended value
module memory_receive_load_formatter
    import memory_receive_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LOG2_NUM_BYTES = log2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic [LOG2_NUM_BYTES-1:0] offset,
    input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
    input  logic                      is_unsigned,
    output logic [DATA_WIDTH-1:0]     result
);

    logic [DATA_WIDTH-1:0] shifted;

    // Misaligned half/word offsets simply shift; upper bytes fill with zero.
    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = '0;
        case (int'(log2_bytes))
            int'(SIZE_BYTE): result = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}},  shifted[7:0]};
            int'(SIZE_HALF): result = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            int'(SIZE_WORD): result = shifted;
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/memory_receive.sv
// memory_receive
//   Matches returning memory words to issued loads in order, formats them
//   and hands the result to writeback as a one-cycle registered pulse.
//   Ports:
//     clock, reset (async, active low)
//     issue_*          in  load issued this cycle and its attributes
//     issue_stall      out pending queue full
//     memory_valid/data in returned read word
//     load_valid/rd/data out formatted result (valid is a 1-cycle pulse)
//     outstanding      out pending queue occupancy
//     response_error   out sticky protocol violation (push when full / pop when empty)
//     scan             in  per-cycle simulation trace enable
module memory_receive
    import memory_receive_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 20,
    parameter int NUM_BYTES       = DATA_WIDTH / 8,
    parameter int LOG2_NUM_BYTES  = log2(NUM_BYTES),
    parameter int PENDING_DEPTH   = 4,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            issue_load,
    input  logic [LOG2_NUM_BYTES-1:0]       issue_offset,
    input  logic [LOG2_NUM_BYTES-1:0]       issue_log2_bytes,
    input  logic                            issue_unsigned,
    input  logic [4:0]                      issue_rd,
    output logic                            issue_stall,
    input  logic                            memory_valid,
    input  logic [DATA_WIDTH-1:0]           memory_data,
    output logic                            load_valid,
    output logic [4:0]                      load_rd,
    output logic [DATA_WIDTH-1:0]           load_data,
    output logic [log2(PENDING_DEPTH):0]    outstanding,
    output logic                            response_error,
    input  logic                            scan
);

    localparam int PTR_W = log2(PENDING_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [LOG2_NUM_BYTES-1:0] offset;
        logic [LOG2_NUM_BYTES-1:0] log2_bytes;
        logic                      is_unsigned;
        logic [4:0]                rd;
    } pend_t;

    pend_t                 pend_q [PENDING_DEPTH];
    pend_t                 pend_d [PENDING_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  load_valid_q, load_valid_d;
    logic [4:0]            load_rd_q, load_rd_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  error_q, error_d;
    logic [31:0]           cycle_q, cycle_d;

    logic                  push, pop, empty;
    pend_t                 head;
    logic [DATA_WIDTH-1:0] formatted;

    // Stall is a pure decode of registered occupancy, so it never depends on
    // a same-cycle response freeing a slot.
    assign issue_stall = (count_q == CNT_W'(PENDING_DEPTH));
    assign empty       = (count_q == '0);
    // A same-cycle push into an empty queue is not visible to the pop.
    assign push        = issue_load & ~issue_stall;
    assign pop         = memory_valid & ~empty;
    assign head        = pend_q[rd_ptr_q];

    memory_receive_load_formatter #(
        .DATA_WIDTH     (DATA_WIDTH),
        .LOG2_NUM_BYTES (LOG2_NUM_BYTES)
    ) u_formatter (
        .data        (memory_data),
        .offset      (head.offset),
        .log2_bytes  (head.log2_bytes),
        .is_unsigned (head.is_unsigned),
        .result      (formatted)
    );

    always_comb begin
        for (int i = 0; i < PENDING_DEPTH; i++) pend_d[i] = pend_q[i];
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        load_valid_d = pop;
        load_rd_d    = load_rd_q;
        load_data_d  = load_data_q;
        error_d      = error_q | (issue_load & issue_stall) | (memory_valid & empty);
        cycle_d      = cycle_q + 32'd1;

        if (push) begin
            pend_d[wr_ptr_q] = '{offset:      issue_offset,
                                 log2_bytes:  issue_log2_bytes,
                                 is_unsigned: issue_unsigned,
                                 rd:          issue_rd};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            load_rd_d   = head.rd;
            load_data_d = formatted;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PENDING_DEPTH; i++) pend_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            load_valid_q <= 1'b0;
            load_rd_q    <= '0;
            load_data_q  <= '0;
            error_q      <= 1'b0;
            cycle_q      <= '0;
        end else begin
            for (int i = 0; i < PENDING_DEPTH; i++) pend_q[i] <= pend_d[i];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            load_valid_q <= load_valid_d;
            load_rd_q    <= load_rd_d;
            load_data_q  <= load_data_d;
            error_q      <= error_d;
            cycle_q      <= cycle_d;
        end
    end

    assign load_valid     = load_valid_q;
    assign load_rd        = load_rd_q;
    assign load_data      = load_data_q;
    assign outstanding    = count_q;
    assign response_error = error_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && scan && int'(cycle_q) >= SCAN_CYCLES_MIN && int'(cycle_q) <= SCAN_CYCLES_MAX)
            $display("core%0d rx cyc=%0d abits=%0d wr=%0d rd=%0d occ=%0d stall=%b head_rd=%0d lv=%b lrd=%0d ldata=%h err=%b",
                     CORE, cycle_q, ADDRESS_BITS, wr_ptr_q, rd_ptr_q, count_q, issue_stall,
                     head.rd, load_valid_q, load_rd_q, load_data_q, error_q);
    end
`endif

endmodule

// File: tb/tb_memory_receive.sv
module tb_memory_receive;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_load = 1'b0;
    logic [1:0]  issue_offset = '0;
    logic [1:0]  issue_log2_bytes = '0;
    logic        issue_unsigned = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_stall;
    logic        memory_valid = 1'b0;
    logic [31:0] memory_data = '0;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic [2:0]  outstanding;
    logic        response_error;
    logic        scan = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } resp_t;
    resp_t sb[$];

    memory_receive dut (
        .clock            (clock),
        .reset            (reset),
        .issue_load       (issue_load),
        .issue_offset     (issue_offset),
        .issue_log2_bytes (issue_log2_bytes),
        .issue_unsigned   (issue_unsigned),
        .issue_rd         (issue_rd),
        .issue_stall      (issue_stall),
        .memory_valid     (memory_valid),
        .memory_data      (memory_data),
        .load_valid       (load_valid),
        .load_rd          (load_rd),
        .load_data        (load_data),
        .outstanding      (outstanding),
        .response_error   (response_error),
        .scan             (scan)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every load_valid pulse must match the oldest expected response.
    always @(negedge clock) begin
        if (reset && load_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual rd=%0d data=%h expected none", load_rd, load_data);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("result_rd", 32'(load_rd), 32'(e.rd));
                chk("result_data", load_data, e.data);
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the edge.
    task automatic cyc(input logic ld, input logic [1:0] off, input logic [1:0] sz,
                       input logic uns, input logic [4:0] rd,
                       input logic mv, input logic [31:0] md);
        issue_load = ld; issue_offset = off; issue_log2_bytes = sz;
        issue_unsigned = uns; issue_rd = rd;
        memory_valid = mv; memory_data = md;
        @(posedge clock); #1;
        issue_load = 1'b0; memory_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] off, input logic [1:0] sz, input logic uns, input logic [4:0] rd);
        cyc(1'b1, off, sz, uns, rd, 1'b0, '0);
    endtask

    task automatic respond(input logic [31:0] md, input logic [4:0] exp_rd, input logic [31:0] exp_data);
        sb.push_back('{rd: exp_rd, data: exp_data});
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("reset_outstanding", 32'(outstanding), 0);
        chk("reset_load_valid", 32'(load_valid), 0);
        chk("reset_load_data", load_data, 0);
        chk("reset_error", 32'(response_error), 0);
        chk("reset_stall", 32'(issue_stall), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // 1: LB signed offset 2
        issue(2'd2, 2'd0, 1'b0, 5'd5);
        chk("t1_outstanding", 32'(outstanding), 1);
        respond(32'h1280_7F00, 5'd5, 32'hFFFF_FF80);
        idle(1);
        chk("t1_drain", 32'(outstanding), 0);

        // 2: LHU offset 2, LW offset 0 back-to-back
        issue(2'd2, 2'd1, 1'b1, 5'd6);
        issue(2'd0, 2'd2, 1'b0, 5'd7);
        chk("t2_outstanding", 32'(outstanding), 2);
        respond(32'hBEEF_1234, 5'd6, 32'h0000_BEEF);
        respond(32'h0000_0042, 5'd7, 32'h0000_0042);
        idle(1);
        chk("t2_drain", 32'(outstanding), 0);
        chk("t2_no_error", 32'(response_error), 0);

        // 3: fill to full, overflow attempt, one response clears stall
        issue(2'd0, 2'd2, 1'b0, 5'd1);
        issue(2'd0, 2'd1, 1'b0, 5'd2);
        issue(2'd3, 2'd0, 1'b1, 5'd3);
        issue(2'd1, 2'd0, 1'b0, 5'd4);
        chk("t3_stall", 32'(issue_stall), 1);
        chk("t3_full", 32'(outstanding), 4);
        chk("t3_error_before", 32'(response_error), 0);
        issue(2'd0, 2'd2, 1'b0, 5'd9);
        chk("t3_overflow_error", 32'(response_error), 1);
        chk("t3_queue_unchanged", 32'(outstanding), 4);
        respond(32'hA5A5_5A5A, 5'd1, 32'hA5A5_5A5A);
        chk("t3_stall_drop", 32'(issue_stall), 0);

        // 4: down to occupancy 2, then simultaneous push+pop across pointer wrap
        respond(32'h0000_8001, 5'd2, 32'hFFFF_8001);
        chk("t4_occ2", 32'(outstanding), 2);
        sb.push_back('{rd: 5'd3, data: 32'h0000_00FF});
        cyc(1'b1, 2'd0, 2'd2, 1'b0, 5'd10, 1'b1, 32'hFF00_0000);
        chk("t4_simul_occ", 32'(outstanding), 2);
        respond(32'h0000_7F00, 5'd4, 32'h0000_007F);
        respond(32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF);
        idle(1);
        chk("t4_drain", 32'(outstanding), 0);

        // 5: response with empty queue
        do_reset();
        chk("t5_error_cleared", 32'(response_error), 0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h1111_1111);
        chk("t5_no_valid", 32'(load_valid), 0);
        chk("t5_error_set", 32'(response_error), 1);
        idle(2);
        chk("t5_error_sticky", 32'(response_error), 1);

        // 6: async reset mid-stream with three loads pending
        do_reset();
        issue(2'd0, 2'd2, 1'b0, 5'd11);
        respond(32'h1234_5678, 5'd11, 32'h1234_5678);
        issue(2'd0, 2'd2, 1'b0, 5'd12);
        issue(2'd1, 2'd0, 1'b1, 5'd13);
        issue(2'd2, 2'd1, 1'b0, 5'd14);
        chk("t6_pending", 32'(outstanding), 3);
        chk("t6_data_before", load_data, 32'h1234_5678);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_outstanding", 32'(outstanding), 0);
        chk("t6_async_data", load_data, 0);
        chk("t6_async_rd", 32'(load_rd), 0);
        chk("t6_async_valid", 32'(load_valid), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h2222_2222);
        chk("t6_post_reset_error", 32'(response_error), 1);
        idle(2);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
